// File: rtl/div_edge_counter_slice_pkg.sv
// Shared constants for the divided-clock edge counter slices.
//   DefWidth    default counter width
//   DefTimeout  default watchdog limit in clk cycles
//   DefWdWidth  watchdog counter width for the default limit
//   wd_width()  watchdog counter width for an arbitrary limit
package div_edge_pkg;

  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefTimeout = 16;

  // Wide enough to hold the value TIMEOUT itself, which is where the counter saturates.
  function automatic int unsigned wd_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int unsigned DefWdWidth = $clog2(DefTimeout + 1);

endpackage

// File: rtl/div_edge_counter_slice_voter.sv
// Bitwise 2-of-3 majority voter.
//   a, b, c  the three redundant copies
//   voted    per-bit majority of a, b and c
module majorityVoter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] voted
);

  assign voted = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/div_edge_counter_slice.sv
// One slice of the triplicated divided-clock edge counter.
// Synchronises divClkIn into the clk domain, detects its rising edges and counts them
// modulo (tcValue + 1). The count register loads the majority of all three slices'
// proposed next counts, so a single corrupted slice is outvoted.
// Optional feature macro: WATCHDOG_EN adds a no-edge watchdog driving timeout.
// Ports:
//   clk, rstn                  system clock, async active-low reset
//   divClkIn                   divided clock from the matching divider slice (async)
//   enable                     count enable
//   tcValue                    terminal count (quasi-static)
//   cntNext                    this slice's proposed next count
//   cntNextA/cntNextB/cntNextC proposed next counts from slices A/B/C
//   count                      registered count
//   edgeStb                    one-cycle pulse per synchronised rising edge
//   tcStb                      one-cycle pulse when count wraps to 0
//   voteErr                    pulse in the cycle after voter inputs disagreed
//   timeout                    no-edge watchdog flag (0 without WATCHDOG_EN)
module div_edge_counter_slice
  import div_edge_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             divClkIn,
  input  logic             enable,
  input  logic [WIDTH-1:0] tcValue,
  output logic [WIDTH-1:0] cntNext,
  input  logic [WIDTH-1:0] cntNextA,
  input  logic [WIDTH-1:0] cntNextB,
  input  logic [WIDTH-1:0] cntNextC,
  output logic [WIDTH-1:0] count,
  output logic             edgeStb,
  output logic             tcStb,
  output logic             voteErr,
  output logic             timeout
);

  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] cnt_voted;
  logic             tc_stb_q;
  logic             vote_err_q;
  logic             wrap;
  logic             vote_mismatch;

  // Two-flop synchroniser plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= divClkIn;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edgeStb = s2_q & ~s3_q;

  // Proposed next count. Using >= rather than == also wraps when tcValue has been
  // lowered below the current count, so the increment can never overflow.
  always_comb begin
    cntNext = count_q;
    wrap    = 1'b0;
    if (enable && edgeStb) begin
      if (count_q >= tcValue) begin
        cntNext = '0;
        wrap    = 1'b1;
      end else begin
        cntNext = count_q + WIDTH'(1);
      end
    end
  end

  majorityVoter #(
    .WIDTH (WIDTH)
  ) cntNextVoter (
    .a     (cntNextA),
    .b     (cntNextB),
    .c     (cntNextC),
    .voted (cnt_voted)
  );

  assign vote_mismatch = (cntNextA != cntNextB) || (cntNextB != cntNextC);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q    <= '0;
      tc_stb_q   <= 1'b0;
      vote_err_q <= 1'b0;
    end else begin
      count_q    <= cnt_voted;
      tc_stb_q   <= wrap;
      vote_err_q <= vote_mismatch;
    end
  end

  assign count   = count_q;
  assign tcStb   = tc_stb_q;
  assign voteErr = vote_err_q;

`ifdef WATCHDOG_EN
  // Local, non-voted watchdog: counts clk cycles since the last edge while enabled.
  localparam int unsigned WdWidth = wd_width(TIMEOUT);
  localparam logic [WdWidth-1:0] WdLimit = WdWidth'(TIMEOUT);

  logic [WdWidth-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (edgeStb || !enable) begin
      wd_d = '0;
    end else if (wd_q != WdLimit) begin
      wd_d = wd_q + WdWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign timeout = (wd_q == WdLimit);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_div_edge_counter_slice.sv
module tb_div_edge_counter_slice;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rstn;
  logic         div_clk;
  logic         en;
  logic [W-1:0] tc;
  logic         corrupt;

  logic [W-1:0] nx   [3];
  logic [W-1:0] cnt  [3];
  logic         edg  [3];
  logic         tcs  [3];
  logic         verr [3];
  logic         tmo  [3];
  logic [W-1:0] bus_b;

  int n_chk;
  int n_err;

  assign bus_b = corrupt ? 8'hFF : nx[1];

  for (genvar g = 0; g < 3; g++) begin : g_slice
    div_edge_counter_slice #(
      .WIDTH   (W),
      .TIMEOUT (16)
    ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .divClkIn (div_clk),
      .enable   (en),
      .tcValue  (tc),
      .cntNext  (nx[g]),
      .cntNextA (nx[0]),
      .cntNextB (bus_b),
      .cntNextC (nx[2]),
      .count    (cnt[g]),
      .edgeStb  (edg[g]),
      .tcStb    (tcs[g]),
      .voteErr  (verr[g]),
      .timeout  (tmo[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         div;
    logic [W-1:0] cnt;
    logic         edg;
    logic         tcs;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clk and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One divClkIn period: 2 cycles high, 2 low. Count has updated by the end.
  task automatic pulse(output int n_edges, output int n_tc);
    n_edges = 0;
    n_tc    = 0;
    for (int i = 0; i < 4; i++) begin
      div_clk = (i < 2);
      tick();
      if (edg[0]) n_edges++;
      if (tcs[0]) n_tc++;
    end
  endtask

  int ne, nt, acc;

  initial begin
    n_chk   = 0;
    n_err   = 0;
    rstn    = 1'b1;
    div_clk = 1'b0;
    en      = 1'b1;
    tc      = 8'd3;
    corrupt = 1'b0;

    //             div cnt edg tcs
    vecs[0]  = '{1'b1, 8'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'd1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'd1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'd1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'd2, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'd2, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'd3, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'd3, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'd3, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 8'd3, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'd0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 8'd0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'd0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 8'd0, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 8'd1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 8'd1, 1'b0, 1'b0};

    // Reset state
    #1 rstn = 1'b0;
    #11;
    chk("rst_count", 32'(cnt[0]), 0);
    chk("rst_cntnext", 32'(nx[0]), 0);
    chk("rst_edge", 32'(edg[0]), 0);
    chk("rst_tcstb", 32'(tcs[0]), 0);
    chk("rst_voteerr", 32'(verr[0]), 0);
    chk("rst_timeout", 32'(tmo[0]), 0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Counting with tcValue=3, 4-cycle divClkIn period
    for (int i = 0; i < 20; i++) begin
      div_clk = vecs[i].div;
      tick();
      chk($sformatf("vec%0d_count", i), 32'(cnt[0]), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_edge", i), 32'(edg[0]), 32'(vecs[i].edg));
      chk($sformatf("vec%0d_tcstb", i), 32'(tcs[0]), 32'(vecs[i].tcs));
    end

    // Disabled for 5 edges: count frozen, edgeStb keeps pulsing
    en  = 1'b0;
    acc = 0;
    for (int p = 0; p < 5; p++) begin
      pulse(ne, nt);
      acc += ne;
      chk($sformatf("dis%0d_count", p), 32'(cnt[0]), 1);
    end
    chk("dis_edges", 32'(acc), 5);
    en = 1'b1;
    pulse(ne, nt);
    chk("resume_count", 32'(cnt[0]), 2);
    chk("resume_edges", 32'(ne), 1);

    // One corrupted voter input is outvoted in every slice
    corrupt = 1'b1;
    tick();
    corrupt = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("tmr_count%0d", s), 32'(cnt[s]), 2);
      chk($sformatf("tmr_verr%0d", s), 32'(verr[s]), 1);
    end
    tick();
    chk("tmr_verr_clear", 32'(verr[0]), 0);
    chk("tmr_count_hold", 32'(cnt[0]), 2);

    // tcValue lowered below the current count
    tc = 8'd10;
    for (int p = 0; p < 5; p++) pulse(ne, nt);
    chk("tc10_count", 32'(cnt[0]), 7);
    tc = 8'd2;
    pulse(ne, nt);
    chk("tclow_count", 32'(cnt[0]), 0);
    chk("tclow_tcstb", 32'(nt), 1);
    for (int s = 1; s < 3; s++) chk($sformatf("tclow_count%0d", s), 32'(cnt[s]), 0);

    // tcValue=0: count stays 0, tcStb on every edge
    tc = 8'd0;
    acc = 0;
    for (int p = 0; p < 3; p++) begin
      pulse(ne, nt);
      acc += nt;
      chk($sformatf("tc0_count%0d", p), 32'(cnt[0]), 0);
    end
    chk("tc0_tcstb", 32'(acc), 3);

    // Asynchronous reset mid-count
    tc = 8'd10;
    for (int p = 0; p < 5; p++) pulse(ne, nt);
    chk("pre_rst_count", 32'(cnt[0]), 5);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_count", 32'(cnt[0]), 0);
    chk("mid_rst_cntnext", 32'(nx[0]), 0);
    chk("mid_rst_edge", 32'(edg[0]), 0);
    chk("mid_rst_tcstb", 32'(tcs[0]), 0);
    chk("mid_rst_timeout", 32'(tmo[0]), 0);
    div_clk = 1'b1;
    @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    chk("rel1_edge", 32'(edg[0]), 0);
    tick();
    chk("rel2_edge", 32'(edg[0]), 1);
    chk("rel2_count", 32'(cnt[0]), 0);
    tick();
    chk("rel3_edge", 32'(edg[0]), 0);
    chk("rel3_count", 32'(cnt[0]), 1);
    div_clk = 1'b0;
    tick();
    tick();

    // Watchdog
    pulse(ne, nt);
`ifdef WATCHDOG_EN
    for (int i = 0; i < 14; i++) tick();
    chk("wd_before", 32'(tmo[0]), 0);
    tick();
    chk("wd_hit", 32'(tmo[0]), 1);
    tick();
    chk("wd_sat", 32'(tmo[0]), 1);
    div_clk = 1'b1;
    tick();
    tick();
    chk("wd_edge_cycle", 32'(tmo[0]), 1);
    tick();
    chk("wd_cleared", 32'(tmo[0]), 0);
    div_clk = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("wd_off%0d", i), 32'(tmo[0]), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/div_edge_counter_slice.md
# div_edge_counter_slice

One triplicated slice of the divided-clock edge counter, sitting directly downstream of the TMR clock-divider slices. It synchronises one divider output into the system clock domain and detects its rising edges. It counts those edges modulo a programmable terminal value and reports a terminal-count strobe. The count register is protected in the same slice-with-voted-feedback style as the divider: each slice publishes its next state, and a majority voter inside each slice combines all three before the register loads.

## Interface
- WIDTH, 8, counter width in bits
- TIMEOUT, 16, clk cycles without a divClkIn rising edge before timeout asserts (WATCHDOG_EN only)
- clk  input  1  system clock, rising edge
- rstn  input  1  asynchronous, active-low reset
- divClkIn  input  1  divided clock from the matching divider slice; asynchronous to clk
- enable  input  1  count enable; synchronous to clk
- tcValue  input  WIDTH  terminal count; quasi-static
- cntNext  output  WIDTH  this slice's proposed next count
- cntNextA / cntNextB / cntNextC  input  WIDTH  cntNext from slices A/B/C
- count  output  WIDTH  registered count
- edgeStb  output  1  one-cycle pulse per synchronised rising edge of divClkIn
- tcStb  output  1  one-cycle pulse on wrap to 0
- voteErr  output  1  one-cycle pulse per cycle in which the voter inputs disagree
- timeout  output  1  no-edge watchdog flag

## Operation
- Synchroniser: two flops s1 -> s2, plus a delay flop s3.
  - edgeStb = s2 & ~s3 (combinational from flops).
- Voter: cntVoted is the bitwise majority of cntNextA/B/C.
  - The count register loads cntVoted on every clk edge.
- cntNext is combinational from count:
  - enable=0 or edgeStb=0: cntNext = count.
  - enable=1, edgeStb=1, count >= tcValue: cntNext = 0.
  - Otherwise: cntNext = count+1.
  - The increment is WIDTH-bit and never overflows, because the wrap happens at tcValue at the latest.
- tcStb is registered. It is set for one cycle on the same edge at which count loads 0 through a wrap.
- tcValue=0: count stays 0, and tcStb pulses on every enabled edge.
- tcValue lowered below the current count: the next enabled edge wraps to 0.
- voteErr is registered: it is 1 in the cycle after any cycle where cntNextA, cntNextB and cntNextC are not all equal. It is not sticky.
- A single corrupted slice input is outvoted. count in all three slices stays identical.
- edgeStb is produced even when enable=0; only counting is gated.

## Timing
- Reset (rstn=0): s1, s2, s3, count, tcStb, voteErr and the watchdog are all 0.
  - Therefore edgeStb=0, tcStb=0, voteErr=0, timeout=0, count=0 and cntNext=0.
  - Reset takes effect immediately, including mid-count.
- Let E0 be the first clk edge that samples divClkIn=1.
  - edgeStb is high between E1 and E2.
  - count updates at E2.
  - Edge-to-count latency is 2 clk cycles.
- If divClkIn is high at reset release, one edgeStb occurs 2 cycles after release. This is defined behaviour and is counted if enable=1.
- divClkIn must stay high and low for at least 2 clk cycles each; shorter pulses may be missed.

## Configuration
- WATCHDOG_EN defined:
  - A local (non-voted) cycle counter of $clog2(TIMEOUT+1) bits.
  - The counter clears on edgeStb or enable=0, and saturates at TIMEOUT.
  - timeout=1 while the counter equals TIMEOUT.
  - timeout clears the cycle after the next edgeStb.
- WATCHDOG_EN undefined: no counter; timeout is tied to 0.

## Structure
- Shared package div_edge_pkg holds:
  - default WIDTH (8) and TIMEOUT (16);
  - the clog2-based watchdog-width constant.
- Sub-module: instantiate the existing majorityVoter with WIDTH=WIDTH (instance cntNextVoter).
- Triplication happens in the parent: three slices cross-connect cntNext into every slice's cntNextA/B/C.

## Test plan
- Reset, then a 4-cycle-period divClkIn with tcValue=3, enable=1 -> count 1,2,3,0,1…; tcStb on every 4th edge; edgeStb 2 cycles after each rise.
- enable=0 for 5 edges, then enable=1 -> count frozen during disable; edgeStb still pulses; counting resumes from the held value.
- Three-slice TMR: force cntNextB=8'hFF for 1 cycle -> count unchanged in all slices; voteErr pulses once.
- tcValue changed 10 -> 2 while count=7 -> next enabled edge gives count=0 and tcStb=1.
- rstn asserted mid-count (count=5) -> all outputs 0 immediately. Releasing rstn with divClkIn=1 -> one edgeStb 2 cycles later and count=1.
- WATCHDOG_EN with TIMEOUT=16, divClkIn held low -> timeout=1 from cycle 16 after the last edgeStb; clears the cycle after the next edgeStb. Without the macro, timeout stays 0.
